// File: rtl/alu_entry_pkg.sv
// Shared types and constants for the calculator entry sequencer.
// ALU_ENTRY_BKSP_EN adds a backspace event to the decode set.
package alu_entry_pkg;

    typedef enum logic [1:0] {
        StEnterA = 2'd0,
        StEnterB = 2'd1,
        StExec   = 2'd2,
        StShow   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpAnd = 2'd2,
        OpOr  = 2'd3
    } op_t;

    // One winning button event per cycle, after priority resolution.
    typedef enum logic [2:0] {
        EvNone,
        EvClear,
        EvEnter,
        EvOp,
        EvBksp,
        EvDigit
    } event_t;

    localparam int unsigned DEC_BASE    = 10;
    localparam int unsigned MAX_OPERAND = 9999;

    localparam logic [1:0] DispA      = 2'd0;
    localparam logic [1:0] DispB      = 2'd1;
    localparam logic [1:0] DispResult = 2'd2;

    // Lowest set operator bit wins.
    function automatic op_t op_decode(input logic [3:0] press);
        op_t op;
        op = OpAdd;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) op = op_t'(2'(i));
        end
        return op;
    endfunction

    // Highest set digit bit wins.
    function automatic logic [3:0] digit_decode(input logic [9:0] press);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            if (press[i]) d = 4'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/digit_accum.sv
// Decimal operand accumulator: value/count register with clear, load and push-digit.
// ALU_ENTRY_BKSP_EN adds a pop (divide by ten) input.
module digit_accum
    import alu_entry_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic [CNT_W-1:0]  load_cnt,
    input  logic              push,
    input  logic [3:0]        digit,
`ifdef ALU_ENTRY_BKSP_EN
    input  logic              pop,
`endif
    output logic [DATA_W-1:0] value
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_val;
            count <= load_cnt;
`ifdef ALU_ENTRY_BKSP_EN
        end else if (pop) begin
            if (count != '0) begin
                value <= value / DATA_W'(DEC_BASE);
                count <= count - CNT_W'(1);
            end
`endif
        end else if (push && (count < CNT_W'(MAX_DIGITS))) begin
            // value < 10^(MAX_DIGITS-1) here, so the truncation never loses bits.
            value <= DATA_W'(({4'd0, value} * (DATA_W + 4)'(DEC_BASE)) + (DATA_W + 4)'(digit));
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_entry_ctrl.sv
// Pushbutton calculator front end: collects A, op, B and runs one req/ack ALU transaction.
// Define ALU_ENTRY_BKSP_EN to add the pb_bksp backspace button.
module alu_entry_ctrl
    import alu_entry_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned RES_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pb_digit,
    input  logic [3:0]        pb_op,
    input  logic              pb_enter,
    input  logic              pb_clear,
`ifdef ALU_ENTRY_BKSP_EN
    input  logic              pb_bksp,
`endif
    output logic              alu_req,
    input  logic              alu_ack,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_err,
    output logic [RES_W-1:0]  disp_value,
    output logic [1:0]        disp_sel,
    output logic              busy,
    output logic              error
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               error_q, error_d;

    logic [9:0]         pb_digit_q;
    logic [3:0]         pb_op_q;
    logic               pb_enter_q, pb_clear_q;
    logic [9:0]         digit_press;
    logic [3:0]         op_press;
    logic               enter_press, clear_press;
`ifdef ALU_ENTRY_BKSP_EN
    logic               pb_bksp_q, bksp_press;
    logic               a_pop, b_pop;
`endif

    event_t             ev;
    logic [3:0]         digit_sel;
    logic               a_clr, a_load, a_push, b_clr, b_push;
    logic [DATA_W-1:0]  a_load_val, a_value, b_value;
    logic [CNT_W-1:0]   a_load_cnt;

    assign digit_press = pb_digit & ~pb_digit_q;
    assign op_press    = pb_op & ~pb_op_q;
    assign enter_press = pb_enter & ~pb_enter_q;
    assign clear_press = pb_clear & ~pb_clear_q;
`ifdef ALU_ENTRY_BKSP_EN
    assign bksp_press  = pb_bksp & ~pb_bksp_q;
`endif
    assign digit_sel   = digit_decode(digit_press);

    always_comb begin
        ev = EvNone;
        if (clear_press)       ev = EvClear;
        else if (enter_press)  ev = EvEnter;
        else if (|op_press)    ev = EvOp;
`ifdef ALU_ENTRY_BKSP_EN
        else if (bksp_press)   ev = EvBksp;
`endif
        else if (|digit_press) ev = EvDigit;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        result_d   = result_q;
        error_d    = error_q;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_push     = 1'b0;
        a_load_val = '0;
        a_load_cnt = '0;
        b_clr      = 1'b0;
        b_push     = 1'b0;
`ifdef ALU_ENTRY_BKSP_EN
        a_pop      = 1'b0;
        b_pop      = 1'b0;
`endif
        if (ev == EvClear) begin
            state_d  = StEnterA;
            op_d     = OpAdd;
            result_d = '0;
            error_d  = 1'b0;
            a_clr    = 1'b1;
            b_clr    = 1'b1;
        end else begin
            unique case (state_q)
                StEnterA: begin
                    case (ev)
                        EvOp: begin
                            op_d    = op_decode(op_press);
                            state_d = StEnterB;
                        end
                        EvDigit: a_push = 1'b1;
`ifdef ALU_ENTRY_BKSP_EN
                        EvBksp:  a_pop  = 1'b1;
`endif
                        default: ;
                    endcase
                end
                StEnterB: begin
                    case (ev)
                        EvEnter: state_d = StExec;
                        EvOp:    op_d    = op_decode(op_press);
                        EvDigit: b_push  = 1'b1;
`ifdef ALU_ENTRY_BKSP_EN
                        EvBksp:  b_pop   = 1'b1;
`endif
                        default: ;
                    endcase
                end
                StExec: begin
                    if (alu_ack) begin
                        result_d = alu_result;
                        error_d  = alu_err;
                        state_d  = StShow;
                    end
                end
                StShow: begin
                    if (ev == EvDigit) begin
                        a_load     = 1'b1;
                        a_load_val = DATA_W'(digit_sel);
                        a_load_cnt = CNT_W'(1);
                        b_clr      = 1'b1;
                        op_d       = OpAdd;
                        error_d    = 1'b0;
                        state_d    = StEnterA;
                    end else if (ev == EvOp && !error_q &&
                                 result_q <= RES_W'(MAX_OPERAND)) begin
                        // Chain: previous result becomes a full-width operand A.
                        a_load     = 1'b1;
                        a_load_val = result_q[DATA_W-1:0];
                        a_load_cnt = CNT_W'(MAX_DIGITS);
                        b_clr      = 1'b1;
                        op_d       = op_decode(op_press);
                        state_d    = StEnterB;
                    end
                end
                default: state_d = StEnterA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEnterA;
            op_q       <= OpAdd;
            result_q   <= '0;
            error_q    <= 1'b0;
            pb_digit_q <= '0;
            pb_op_q    <= '0;
            pb_enter_q <= 1'b0;
            pb_clear_q <= 1'b0;
`ifdef ALU_ENTRY_BKSP_EN
            pb_bksp_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            result_q   <= result_d;
            error_q    <= error_d;
            pb_digit_q <= pb_digit;
            pb_op_q    <= pb_op;
            pb_enter_q <= pb_enter;
            pb_clear_q <= pb_clear;
`ifdef ALU_ENTRY_BKSP_EN
            pb_bksp_q  <= pb_bksp;
`endif
        end
    end

    digit_accum #(
        .MAX_DIGITS (MAX_DIGITS),
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W)
    ) u_accum_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (a_clr),
        .load     (a_load),
        .load_val (a_load_val),
        .load_cnt (a_load_cnt),
        .push     (a_push),
        .digit    (digit_sel),
`ifdef ALU_ENTRY_BKSP_EN
        .pop      (a_pop),
`endif
        .value    (a_value)
    );

    digit_accum #(
        .MAX_DIGITS (MAX_DIGITS),
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W)
    ) u_accum_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (b_clr),
        .load     (1'b0),
        .load_val ('0),
        .load_cnt ('0),
        .push     (b_push),
        .digit    (digit_sel),
`ifdef ALU_ENTRY_BKSP_EN
        .pop      (b_pop),
`endif
        .value    (b_value)
    );

    assign alu_req = (state_q == StExec);
    assign busy    = (state_q == StExec);
    assign alu_a   = a_value;
    assign alu_b   = b_value;
    assign alu_op  = op_q;
    assign error   = error_q;

    always_comb begin
        disp_sel   = DispA;
        disp_value = RES_W'(a_value);
        unique case (state_q)
            StEnterA: begin
                disp_sel   = DispA;
                disp_value = RES_W'(a_value);
            end
            StEnterB, StExec: begin
                disp_sel   = DispB;
                disp_value = RES_W'(b_value);
            end
            StShow: begin
                disp_sel   = DispResult;
                disp_value = result_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Scoreboard bench for alu_entry_ctrl: directed scenarios followed by random button/ALU traffic.
module tb_alu_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pb_digit;
    logic [3:0]  pb_op;
    logic        pb_enter, pb_clear;
    logic        alu_req, alu_ack, alu_err;
    logic [13:0] alu_a, alu_b;
    logic [1:0]  alu_op, disp_sel;
    logic [15:0] alu_result, disp_value;
    logic        busy, error;

    always #5 clk = ~clk;

    alu_entry_ctrl dut (
`ifdef ALU_ENTRY_BKSP_EN
        .pb_bksp    (1'b0),
`endif
        .clk        (clk),
        .rst        (rst),
        .pb_digit   (pb_digit),
        .pb_op      (pb_op),
        .pb_enter   (pb_enter),
        .pb_clear   (pb_clear),
        .alu_req    (alu_req),
        .alu_ack    (alu_ack),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_err    (alu_err),
        .disp_value (disp_value),
        .disp_sel   (disp_sel),
        .busy       (busy),
        .error      (error)
    );

    localparam int MA = 0, MB = 1, MX = 2, MS = 3;

    typedef struct {
        int sel; int val; int req; int busy; int err;
        bit chk_ops; int a; int b; int op;
    } snap_t;
    typedef struct { int a; int b; int op; } txn_t;

    snap_t exp_q[$];
    txn_t  txn_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Reference model state, written only by the stimulus process.
    int         m_st, m_a, m_acnt, m_b, m_bcnt, m_op, m_res, m_err;
    logic [9:0] m_pd;
    logic [3:0] m_po;
    logic       m_pe, m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_st = MA; m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0;
        m_op = 0; m_res = 0; m_err = 0;
    endtask

    // Drive one cycle of inputs, predict the state after the next edge, queue the expectation.
    task automatic step(input bit r, input logic [9:0] d, input logic [3:0] o, input bit en,
                        input bit cl, input bit ak, input int res, input bit er);
        logic [9:0] dp;
        logic [3:0] opp;
        bit         ep, cp;
        int         dig, opc;
        snap_t      s;
        rst = r; pb_digit = d; pb_op = o; pb_enter = en; pb_clear = cl;
        alu_ack = ak; alu_result = 16'(res); alu_err = er;
        if (r) begin
            model_zero();
            m_pd = '0; m_po = '0; m_pe = 1'b0; m_pc = 1'b0;
        end else begin
            dp = d & ~m_pd; opp = o & ~m_po; ep = en & ~m_pe; cp = cl & ~m_pc;
            m_pd = d; m_po = o; m_pe = en; m_pc = cl;
            dig = 0; opc = 0;
            for (int i = 0; i < 10; i++) if (dp[i]) dig = i;
            for (int i = 3; i >= 0; i--) if (opp[i]) opc = i;
            if (cp) begin
                model_zero();
            end else if (m_st == MA) begin
                if (!ep) begin
                    if (opp != 0) begin m_op = opc; m_st = MB; end
                    else if (dp != 0 && m_acnt < 4) begin m_a = m_a * 10 + dig; m_acnt++; end
                end
            end else if (m_st == MB) begin
                if (ep) begin
                    m_st = MX;
                    txn_q.push_back('{a: m_a, b: m_b, op: m_op});
                end else if (opp != 0) m_op = opc;
                else if (dp != 0 && m_bcnt < 4) begin m_b = m_b * 10 + dig; m_bcnt++; end
            end else if (m_st == MX) begin
                if (ak) begin m_res = res; m_err = er; m_st = MS; end
            end else begin
                if (!ep) begin
                    if (opp != 0) begin
                        if (m_err == 0 && m_res <= 9999) begin
                            m_a = m_res; m_acnt = 4; m_b = 0; m_bcnt = 0; m_op = opc; m_st = MB;
                        end
                    end else if (dp != 0) begin
                        m_a = dig; m_acnt = 1; m_b = 0; m_bcnt = 0; m_op = 0; m_err = 0; m_st = MA;
                    end
                end
            end
        end
        s.sel     = (m_st == MS) ? 2 : (m_st == MA) ? 0 : 1;
        s.val     = (m_st == MS) ? m_res : (m_st == MA) ? m_a : m_b;
        s.req     = (m_st == MX) ? 1 : 0;
        s.busy    = s.req;
        s.err     = m_err;
        s.chk_ops = (m_st == MX) || r;
        s.a = m_a; s.b = m_b; s.op = m_op;
        exp_q.push_back(s);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 0, 0, 0);
    endtask
    task automatic press_d(input int d);
        step(0, 10'(1) << d, '0, 0, 0, 0, 0, 0); idle(1);
    endtask
    task automatic press_op(input int o);
        step(0, '0, 4'(1) << o, 0, 0, 0, 0, 0); idle(1);
    endtask
    task automatic press_enter();
        step(0, '0, '0, 1, 0, 0, 0, 0); idle(1);
    endtask
    task automatic press_clear();
        step(0, '0, '0, 0, 1, 0, 0, 0); idle(1);
    endtask
    task automatic ack(input int res, input bit er);
        step(0, '0, '0, 0, 0, 1, res, er);
    endtask

    // Monitor: pops one expectation per edge and checks every ALU request as it rises.
    initial begin
        snap_t e;
        txn_t  t;
        logic  req_prev;
        req_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("disp_sel", 32'(disp_sel), e.sel);
                check("disp_value", 32'(disp_value), e.val);
                check("alu_req", 32'(alu_req), e.req);
                check("busy", 32'(busy), e.busy);
                check("error", 32'(error), e.err);
                if (e.chk_ops) begin
                    check("alu_a", 32'(alu_a), e.a);
                    check("alu_b", 32'(alu_b), e.b);
                    check("alu_op", 32'(alu_op), e.op);
                end
            end
            if (alu_req === 1'b1 && req_prev !== 1'b1) begin
                check("txn_expected", 32'(txn_q.size() > 0), 1);
                if (txn_q.size() > 0) begin
                    t = txn_q.pop_front();
                    check("txn_a", 32'(alu_a), t.a);
                    check("txn_b", 32'(alu_b), t.b);
                    check("txn_op", 32'(alu_op), t.op);
                end
            end
            req_prev = alu_req;
        end
    end

    initial begin
        // Digit 4 held across reset release registers exactly once.
        step(1, 10'h010, '0, 0, 0, 0, 0, 0);
        step(1, 10'h010, '0, 0, 0, 0, 0, 0);
        step(0, 10'h010, '0, 0, 0, 0, 0, 0);
        step(0, 10'h010, '0, 0, 0, 0, 0, 0);
        idle(1);
        press_clear();
        // 123 + 45 with a delayed ack.
        press_d(1); press_d(2); press_d(3); press_op(0);
        press_d(4); press_d(5);
        step(0, '0, '0, 1, 0, 0, 0, 0);
        idle(1);
        ack(168, 0);
        idle(2);
        // Fifth digit dropped, leading zeros count.
        press_clear();
        press_d(9); press_d(9); press_d(9); press_d(9); press_d(7);
        press_clear();
        press_d(0); press_d(0); press_d(5); press_d(6); press_d(8);
        // Simultaneous digits, then clear with enter.
        press_clear();
        step(0, 10'h088, '0, 0, 0, 0, 0, 0); idle(1);
        press_op(2); press_d(1);
        step(0, '0, '0, 1, 1, 0, 0, 0); idle(2);
        // Clear during EXEC, late ack ignored.
        press_d(2); press_op(3); press_d(3); press_enter();
        press_clear();
        ack(77, 0); idle(2);
        // Oversize result blocks chaining; small result chains; error sticks until digit.
        press_d(1); press_op(0); press_d(2); press_enter(); ack(20000, 0);
        press_op(0); idle(1);
        press_clear();
        press_d(4); press_op(0); press_d(2); press_enter(); ack(42, 0);
        press_op(1); press_d(1); press_enter(); ack(41, 1);
        idle(2); press_op(0); press_d(3); idle(2);

        for (int c = 0; c < 3000; c++) begin
            logic [9:0] d;
            logic [3:0] o;
            bit         en, cl, r, ak, er;
            int         res;
            d = '0;
            if ($urandom_range(0, 2) == 0) d = 10'(1) << $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0) d = d | (10'(1) << $urandom_range(0, 9));
            o = '0;
            if ($urandom_range(0, 7) == 0) o = 4'(1) << $urandom_range(0, 3);
            if ($urandom_range(0, 31) == 0) o = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 9) == 0);
            cl  = ($urandom_range(0, 59) == 0);
            r   = ($urandom_range(0, 399) == 0);
            ak  = (m_st == MX) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            res = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 9999));
            er  = ($urandom_range(0, 4) == 0);
            step(r, d, o, en, cl, ak, res, er);
        end
        idle(3);
        check("txn_leftover", 32'(txn_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
